// File: rtl/mem_io_responder_if.sv
// Bus and UART-side signals between the memory controller / UART and the responder.
interface mem_io_responder_if;
  logic        rdy;
  logic        if_rw;
  logic [31:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        if_uart_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        sim_done;

  modport master (
    output rdy, if_rw, addr_in, data_in, tx_ready, rx_valid, rx_data,
    input  data_out, if_uart_full, tx_valid, tx_data, sim_done
  );

  modport slave (
    input  rdy, if_rw, addr_in, data_in, tx_ready, rx_valid, rx_data,
    output data_out, if_uart_full, tx_valid, tx_data, sim_done
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART TX/RX FIFOs and a program-end strobe.
// IO space is addr_in[17:16] == 2'b11: offset 0x0 is UART data, 0x4 is status / sim_done.
module mem_io_responder #(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_DEPTH      = 8,
  parameter int RX_DEPTH      = 8
) (
  input logic               clk,
  input logic               rst,
  mem_io_responder_if.slave bus
);
  localparam int TXP = $clog2(TX_DEPTH);
  localparam int RXP = $clog2(RX_DEPTH);
  localparam int TXC = TXP + 1;
  localparam int RXC = RXP + 1;
  localparam logic [TXC-1:0] TX_FULL_CNT = TXC'(TX_DEPTH);
  localparam logic [TXC-1:0] TX_MARK     = TXC'(TX_DEPTH - 1);
  localparam logic [RXC-1:0] RX_FULL_CNT = RXC'(RX_DEPTH);

  logic [7:0] ram [0:(2**RAM_ADDR_BITS)-1];
  logic [7:0] tx_mem [0:TX_DEPTH-1];
  logic [7:0] rx_mem [0:RX_DEPTH-1];

  logic [TXP-1:0] tx_wp, tx_rp;
  logic [TXC-1:0] tx_cnt, tx_cnt_nxt;
  logic [RXP-1:0] rx_wp, rx_rp;
  logic [RXC-1:0] rx_cnt, rx_cnt_nxt;
  logic           tx_ovf;

  logic io_sel, off_data, off_ctrl, acc_rd, acc_wr, ram_wr;
  logic tx_push_req, tx_push, tx_pop, tx_drop;
  logic rx_push, rx_pop;
  logic [RAM_ADDR_BITS-1:0] ram_idx;

  // Upper address bits are ignored by the decode; the overflow flag is only observed internally.
  logic unused_bits;
  assign unused_bits = ^{bus.addr_in, tx_ovf};

  assign io_sel   = (bus.addr_in[17:16] == 2'b11);
  assign off_data = (bus.addr_in[15:0] == 16'h0000);
  assign off_ctrl = (bus.addr_in[15:0] == 16'h0004);
  assign acc_rd   = bus.rdy && !bus.if_rw;
  assign acc_wr   = bus.rdy && bus.if_rw;
  assign ram_wr   = acc_wr && !io_sel;
  assign ram_idx  = bus.addr_in[RAM_ADDR_BITS-1:0];

  assign bus.tx_valid = (tx_cnt != '0);
  assign bus.tx_data  = (tx_cnt != '0) ? tx_mem[tx_rp] : 8'h00;

  // FIFO handshake decisions and next occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    tx_pop      = (tx_cnt != '0) && bus.tx_ready;
    tx_push_req = acc_wr && io_sel && off_data;
    tx_push     = tx_push_req && ((tx_cnt != TX_FULL_CNT) || tx_pop);
    tx_drop     = tx_push_req && !tx_push;
    rx_pop      = acc_rd && io_sel && off_data && (rx_cnt != '0);
    rx_push     = bus.rx_valid && ((rx_cnt != RX_FULL_CNT) || rx_pop);
    tx_cnt_nxt  = tx_cnt;
    if (tx_push && !tx_pop) tx_cnt_nxt = tx_cnt + 1'b1;
    else if (!tx_push && tx_pop) tx_cnt_nxt = tx_cnt - 1'b1;
    rx_cnt_nxt  = rx_cnt;
    if (rx_push && !rx_pop) rx_cnt_nxt = rx_cnt + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_nxt = rx_cnt - 1'b1;
  end

  // RAM write port; contents survive reset so the bench can preload a program.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= bus.data_in;
  end

  // FIFO storage arrays, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.data_in;
    if (rx_push) rx_mem[rx_wp] <= bus.rx_data;
  end

  // FIFO pointers, counts, sticky overflow and the early almost-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp            <= '0;
      tx_rp            <= '0;
      tx_cnt           <= '0;
      rx_wp            <= '0;
      rx_rp            <= '0;
      rx_cnt           <= '0;
      tx_ovf           <= 1'b0;
      bus.if_uart_full <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (tx_drop) tx_ovf <= 1'b1;
      tx_cnt           <= tx_cnt_nxt;
      rx_cnt           <= rx_cnt_nxt;
      bus.if_uart_full <= (tx_cnt_nxt >= TX_MARK);
    end
  end

  // Registered read data and the one-cycle program-end strobe; data_out holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out <= 8'h00;
      bus.sim_done <= 1'b0;
    end else begin
      bus.sim_done <= acc_wr && io_sel && off_ctrl;
      if (acc_rd) begin
        if (!io_sel)       bus.data_out <= ram[ram_idx];
        else if (off_data) bus.data_out <= (rx_cnt != '0) ? rx_mem[rx_rp] : 8'h00;
        else if (off_ctrl) bus.data_out <= {7'b0, (tx_cnt == '0)};
        else               bus.data_out <= 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench: a queue-based model predicts read data and TX bytes; a negedge monitor compares.
module tb_mem_io_responder;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic clk, rst;
  logic g_txr;
  mem_io_responder_if bus();

  mem_io_responder #(.RAM_ADDR_BITS(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp, n_bad;
  int exp_rd[$];
  int exp_tx[$];
  int m_rx[$];
  int mram[int];
  int m_tx_cnt;
  bit m_ovf, m_done;
  bit rd_pending;
  int mon_e;
  int tx_hs;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx_cnt = 0;
    exp_tx.delete();
    m_rx.delete();
    exp_rd.delete();
    m_ovf  = 0;
    m_done = 0;
  endtask

  // Apply the effect of the inputs sampled at the edge that just passed.
  task automatic commit();
    bit io, txpop, rxpop;
    int off, key;
    if (rst) begin
      model_reset();
      return;
    end
    io    = (bus.addr_in[17:16] == 2'b11);
    off   = int'(bus.addr_in[15:0]);
    key   = int'(bus.addr_in[16:0]);
    txpop = (m_tx_cnt > 0) && bus.tx_ready;
    rxpop = 0;
    m_done = 0;
    if (bus.rdy && !bus.if_rw) begin
      if (!io) exp_rd.push_back(mram.exists(key) ? mram[key] : -1);
      else if (off == 0) begin
        if (m_rx.size() > 0) begin
          exp_rd.push_back(m_rx[0]);
          rxpop = 1;
        end else exp_rd.push_back(0);
      end
      else if (off == 4) exp_rd.push_back(m_tx_cnt == 0 ? 1 : 0);
      else exp_rd.push_back(0);
    end
    if (bus.rdy && bus.if_rw) begin
      if (!io) mram[key] = int'(bus.data_in);
      else if (off == 0) begin
        if (m_tx_cnt < TXD || txpop) begin
          exp_tx.push_back(int'(bus.data_in));
          m_tx_cnt++;
        end else m_ovf = 1;
      end
      else if (off == 4) m_done = 1;
    end
    if (txpop) m_tx_cnt--;
    if (rxpop) void'(m_rx.pop_front());
    if (bus.rx_valid && m_rx.size() < RXD) m_rx.push_back(int'(bus.rx_data));
  endtask

  task automatic step(input logic r, input logic rw, input logic [31:0] a,
                      input logic [7:0] d, input logic rxv, input logic [7:0] rxd);
    @(posedge clk);
    #2;
    commit();
    bus.rdy      = r;
    bus.if_rw    = rw;
    bus.addr_in  = a;
    bus.data_in  = d;
    bus.tx_ready = g_txr;
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    commit();
    rst = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_uart_full", bus.if_uart_full, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_sim_done", bus.sim_done, 0);
  endtask

  // Monitor: mid-cycle comparison of DUT outputs against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_pending) begin
        if (exp_rd.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_data: got 0x%0h required no response", bus.data_out);
        end else begin
          mon_e = exp_rd.pop_front();
          if (mon_e >= 0) chk("rd_data", bus.data_out, mon_e);
        end
      end
      rd_pending = bus.rdy && !bus.if_rw;
      chk("tx_valid", bus.tx_valid, (m_tx_cnt > 0) ? 1 : 0);
      chk("uart_full", bus.if_uart_full, (m_tx_cnt >= TXD - 1) ? 1 : 0);
      chk("sim_done", bus.sim_done, m_done);
      chk("tx_ovf", dut.tx_ovf, m_ovf);
      if (bus.tx_valid && bus.tx_ready) begin
        tx_hs++;
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_data: got 0x%0h required no byte", bus.tx_data);
        end else chk("tx_data", bus.tx_data, exp_tx.pop_front());
      end
    end else rd_pending = 0;
  end

  int unsigned pool [10] = '{32'h0, 32'h1, 32'h7, 32'h10, 32'h100, 32'h103,
                             32'h200, 32'h1FFFF, 32'hFFFC0010, 32'h10005};
  int unsigned oth [3] = '{32'h30008, 32'h30001, 32'h3FFF0};

  initial begin
    int hs0, k;
    logic r;
    logic [31:0] a;
    n_cmp = 0; n_bad = 0; tx_hs = 0; rd_pending = 0;
    g_txr = 0;
    rst = 0;
    bus.rdy = 0; bus.if_rw = 0; bus.addr_in = 0; bus.data_in = 0;
    bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 0;
    model_reset();
    #1 rst = 1;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    release_reset();

    // Write then read back the same address next cycle.
    wr(32'h10, 8'hA5);
    rd(32'h10);
    idle();

    // Streamed reads of a preloaded block.
    wr(32'h100, 8'h13); wr(32'h101, 8'h05); wr(32'h102, 8'h00); wr(32'h103, 8'h00);
    rd(32'h100); rd(32'h101); rd(32'h102); rd(32'h103);
    idle();

    // RX capture, pop, then empty read.
    step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 8'h41);
    rd(32'h30000);
    rd(32'h30000);
    idle();

    // Program-end strobe.
    wr(32'h30004, 8'h5A);
    idle(); idle();

    // Fill TX with the drain stalled, overflow on the ninth push, then drain.
    g_txr = 0;
    for (int i = 0; i < 9; i++) wr(32'h30000, 8'(8'hB0 + i));
    idle();
    rd(32'h30004);
    g_txr = 1;
    hs0 = tx_hs;
    for (int i = 0; i < 40 && bus.tx_valid; i++) idle();
    idle();
    chk("drain_done", bus.tx_valid, 0);
    chk("drain_count", tx_hs - hs0, 8);

    // Pending TX bytes, rdy-low accesses, then asynchronous reset.
    g_txr = 0;
    wr(32'h200, 8'h77);
    wr(32'h30000, 8'h01); wr(32'h30000, 8'h02); wr(32'h30000, 8'h03);
    rd(32'h200);
    idle();
    step(1'b0, 1'b1, 32'h200, 8'h11, 1'b0, 8'h00);
    step(1'b0, 1'b1, 32'h30000, 8'h99, 1'b0, 8'h00);
    step(1'b0, 1'b0, 32'h30000, 8'h00, 1'b0, 8'h00);
    idle();
    chk("rdy_low_hold", bus.data_out, 8'h77);
    chk("pending_tx", bus.tx_valid, 1);
    #1 rst = 1;
    model_reset();
    #1 check_reset_outputs();
    release_reset();
    rd(32'h200);
    rd(32'h30004);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      g_txr = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) != 0);
      a = pool[$urandom_range(0, 9)];
      k = $urandom_range(0, 9);
      case (k)
        0, 1: step(r, 1'b1, a, 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
        2, 3: step(r, 1'b0, a, 8'h00, ($urandom_range(0, 3) == 0), 8'($urandom));
        4:    step(r, 1'b1, 32'h30000, 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
        5:    step(r, 1'b0, 32'h30000, 8'h00, ($urandom_range(0, 3) == 0), 8'($urandom));
        6:    step(r, 1'b0, 32'h30004, 8'h00, ($urandom_range(0, 3) == 0), 8'($urandom));
        7:    step(r, 1'b1, 32'h30004, 8'($urandom), 1'b0, 8'h00);
        8:    step(r, 1'($urandom_range(0, 1)), oth[$urandom_range(0, 2)], 8'($urandom), 1'b0, 8'h00);
        default: step(1'b0, 1'b0, 32'h0, 8'h00, ($urandom_range(0, 1) == 0), 8'($urandom));
      endcase
    end
    idle(); idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
